// File: rtl/spi_obi_bridge.sv
// OBI subordinate that maps a 128 KiB window onto an SPI SRAM manager, one word access at a time.
// Optional feature macro: SPI_OBI_BRIDGE_RMW_EN (partial writes via read-modify-write instead of an error).
module spi_obi_bridge #(
   parameter int unsigned IdWidth  = 1,
   parameter logic [31:0] BaseAddr = 32'h2000_0000
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               obi_req_i,
   output logic               obi_gnt_o,
   input  logic [31:0]        obi_addr_i,
   input  logic               obi_we_i,
   input  logic [3:0]         obi_be_i,
   input  logic [31:0]        obi_wdata_i,
   input  logic [IdWidth-1:0] obi_aid_i,
   output logic               obi_rvalid_o,
   output logic [31:0]        obi_rdata_o,
   output logic               obi_err_o,
   output logic [IdWidth-1:0] obi_rid_o,
   output logic               spi_start_o,
   output logic               spi_we_o,
   output logic [23:0]        spi_addr_o,
   output logic [31:0]        spi_wdata_o,
   input  logic               spi_rsp_valid_i,
   input  logic [31:0]        spi_rdata_i
);

`ifdef SPI_OBI_BRIDGE_RMW_EN
   typedef enum logic [2:0] {IDLE, RMW_RD, RMW_WAIT, ISSUE, WAIT, RESP} state_t;
`else
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP} state_t;
`endif

   state_t             state;

   logic [16:2]        addr_q;
   logic               we_q;
   logic [3:0]         be_q;
   logic [31:0]        wdata_q;
   logic [IdWidth-1:0] aid_q;

   logic               rvalid_q;
   logic               err_q;
   logic [31:0]        rdata_q;
   logic [IdWidth-1:0] rid_q;
   logic               start_q;
   logic               spi_we_q;
   logic [23:0]        spi_addr_q;
   logic [31:0]        spi_wdata_q;

   logic               win_hit;
   logic               partial;
   logic               unused_sink;

   assign win_hit   = (obi_addr_i[31:17] == BaseAddr[31:17]);
   assign partial   = obi_we_i && (obi_be_i != 4'hF);
   assign obi_gnt_o = rst_ni && (state == IDLE) && obi_req_i;

   // Byte lanes of the request address and the stored request copy are not all consumed in every build.
   assign unused_sink = ^{obi_addr_i[1:0], addr_q, be_q, wdata_q};

`ifdef SPI_OBI_BRIDGE_RMW_EN
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_word;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
      end
      return res;
   endfunction
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state       <= IDLE;
         addr_q      <= '0;
         we_q        <= 1'b0;
         be_q        <= '0;
         wdata_q     <= '0;
         aid_q       <= '0;
         rvalid_q    <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         rid_q       <= '0;
         start_q     <= 1'b0;
         spi_we_q    <= 1'b0;
         spi_addr_q  <= '0;
         spi_wdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (obi_req_i) begin
                  addr_q  <= obi_addr_i[16:2];
                  we_q    <= obi_we_i;
                  be_q    <= obi_be_i;
                  wdata_q <= obi_wdata_i;
                  aid_q   <= obi_aid_i;
                  if (!win_hit) begin
                     state    <= RESP;
                     rvalid_q <= 1'b1;
                     err_q    <= 1'b1;
                     rdata_q  <= '0;
                     rid_q    <= obi_aid_i;
                  end else if (partial) begin
`ifdef SPI_OBI_BRIDGE_RMW_EN
                     // Fetch the old word first; the merged word is issued from RMW_WAIT.
                     state       <= RMW_RD;
                     start_q     <= 1'b1;
                     spi_we_q    <= 1'b0;
                     spi_addr_q  <= {7'b0, obi_addr_i[16:2], 2'b00};
                     spi_wdata_q <= obi_wdata_i;
`else
                     state    <= RESP;
                     rvalid_q <= 1'b1;
                     err_q    <= 1'b1;
                     rdata_q  <= '0;
                     rid_q    <= obi_aid_i;
`endif
                  end else begin
                     state       <= ISSUE;
                     start_q     <= 1'b1;
                     spi_we_q    <= obi_we_i;
                     spi_addr_q  <= {7'b0, obi_addr_i[16:2], 2'b00};
                     spi_wdata_q <= obi_wdata_i;
                  end
               end
            end
`ifdef SPI_OBI_BRIDGE_RMW_EN
            RMW_RD: begin
               start_q <= 1'b0;
               state   <= RMW_WAIT;
            end
            RMW_WAIT: begin
               if (spi_rsp_valid_i) begin
                  spi_wdata_q <= merge_bytes(spi_rdata_i, wdata_q, be_q);
                  spi_we_q    <= 1'b1;
                  start_q     <= 1'b1;
                  state       <= ISSUE;
               end
            end
`endif
            ISSUE: begin
               start_q <= 1'b0;
               state   <= WAIT;
            end
            WAIT: begin
               if (spi_rsp_valid_i) begin
                  rdata_q  <= we_q ? 32'h0 : spi_rdata_i;
                  err_q    <= 1'b0;
                  rid_q    <= aid_q;
                  rvalid_q <= 1'b1;
                  state    <= RESP;
               end
            end
            RESP: begin
               rvalid_q <= 1'b0;
               err_q    <= 1'b0;
               rdata_q  <= '0;
               rid_q    <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign obi_rvalid_o = rvalid_q;
   assign obi_rdata_o  = rdata_q;
   assign obi_err_o    = err_q;
   assign obi_rid_o    = rid_q;
   assign spi_start_o  = start_q;
   assign spi_we_o     = spi_we_q;
   assign spi_addr_o   = spi_addr_q;
   assign spi_wdata_o  = spi_wdata_q;

endmodule

// File: tb/tb_spi_obi_bridge.sv
// Directed bench for spi_obi_bridge: vector table plus reset, back-to-back and stray-response sequences.
module tb_spi_obi_bridge;

   logic        clk;
   logic        rst_n;
   logic        obi_req;
   logic        obi_gnt;
   logic [31:0] obi_addr;
   logic        obi_we;
   logic [3:0]  obi_be;
   logic [31:0] obi_wdata;
   logic [0:0]  obi_aid;
   logic        obi_rvalid;
   logic [31:0] obi_rdata;
   logic        obi_err;
   logic [0:0]  obi_rid;
   logic        spi_start;
   logic        spi_we;
   logic [23:0] spi_addr;
   logic [31:0] spi_wdata;
   logic        spi_rsp_valid;
   logic [31:0] spi_rdata;

   spi_obi_bridge dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .obi_req_i      (obi_req),
      .obi_gnt_o      (obi_gnt),
      .obi_addr_i     (obi_addr),
      .obi_we_i       (obi_we),
      .obi_be_i       (obi_be),
      .obi_wdata_i    (obi_wdata),
      .obi_aid_i      (obi_aid),
      .obi_rvalid_o   (obi_rvalid),
      .obi_rdata_o    (obi_rdata),
      .obi_err_o      (obi_err),
      .obi_rid_o      (obi_rid),
      .spi_start_o    (spi_start),
      .spi_we_o       (spi_we),
      .spi_addr_o     (spi_addr),
      .spi_wdata_o    (spi_wdata),
      .spi_rsp_valid_i(spi_rsp_valid),
      .spi_rdata_i    (spi_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s got %0h expected %0h", tag, what, act, exp);
      end
   endtask

   // SPI SRAM model and monitor: answers each start after three cycles, logs starts and responses.
   logic [31:0] sram [logic [23:0]];
   int          st_cyc[$];
   logic [31:0] st_we[$];
   logic [31:0] st_addr[$];
   logic [31:0] st_wdata[$];
   int          rv_cyc[$];
   logic [31:0] rv_rdata[$];
   logic [31:0] rv_err[$];
   logic [31:0] rv_rid[$];
   int          stab_err = 0;
   int          rsp_cyc = -100;
   logic        stray_rsp = 1'b0;

   initial begin
      int          cnt;
      logic        l_we;
      logic [23:0] l_addr;
      logic [31:0] l_wdata;
      cnt = 0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
      spi_rsp_valid = 1'b0;
      spi_rdata = 32'h0BAD_0BAD;
      forever begin
         @(negedge clk);
         spi_rsp_valid = 1'b0;
         spi_rdata = 32'h0BAD_0BAD;
         if (obi_rvalid === 1'b1) begin
            rv_cyc.push_back(cyc);
            rv_rdata.push_back(obi_rdata);
            rv_err.push_back(32'(obi_err));
            rv_rid.push_back(32'(obi_rid));
         end
         if (!rst_n) begin
            cnt = 0;
         end else begin
            if (spi_start === 1'b1) begin
               st_cyc.push_back(cyc);
               st_we.push_back(32'(spi_we));
               st_addr.push_back(32'(spi_addr));
               st_wdata.push_back(spi_wdata);
            end
            if (cnt > 0) begin
               if (spi_we !== l_we || spi_addr !== l_addr || spi_wdata !== l_wdata) stab_err++;
               cnt--;
               if (cnt == 0) begin
                  spi_rsp_valid = 1'b1;
                  if (l_we) begin
                     spi_rdata = 32'h5A5A_5A5A;
                     sram[l_addr] = l_wdata;
                  end else begin
                     spi_rdata = sram.exists(l_addr) ? sram[l_addr] : 32'h0;
                  end
                  rsp_cyc = cyc;
               end
            end else if (spi_start === 1'b1) begin
               cnt = 3; l_we = spi_we; l_addr = spi_addr; l_wdata = spi_wdata;
            end
         end
         if (stray_rsp) begin
            spi_rsp_valid = 1'b1;
            spi_rdata = 32'hFFFF_FFFF;
         end
      end
   end

   typedef struct {
      string       nm;
      logic [31:0] we, be, addr, wdata, aid;
      logic [31:0] pre, pv;
      int          starts;
      logic [31:0] fwe, lwe, sa, sw, err, rd, rid;
   } vec_t;

   function automatic vec_t mk(string nm, logic [31:0] we, logic [31:0] be, logic [31:0] addr,
                               logic [31:0] wdata, logic [31:0] aid, logic [31:0] pre, logic [31:0] pv,
                               int starts, logic [31:0] fwe, logic [31:0] lwe, logic [31:0] sa,
                               logic [31:0] sw, logic [31:0] err, logic [31:0] rd, logic [31:0] rid);
      vec_t v;
      v.nm = nm; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata; v.aid = aid;
      v.pre = pre; v.pv = pv; v.starts = starts; v.fwe = fwe; v.lwe = lwe;
      v.sa = sa; v.sw = sw; v.err = err; v.rd = rd; v.rid = rid;
      return v;
   endfunction

   task automatic run_txn(input vec_t v);
      int t_gnt, st0, rv0, sb0, ns, nr, last;
      t_gnt = -1;
      if (v.pre[0]) sram[v.sa[23:0]] = v.pv;
      @(negedge clk);
      st0 = st_cyc.size(); rv0 = rv_cyc.size(); sb0 = stab_err;
      obi_req = 1'b1; obi_we = v.we[0]; obi_be = v.be[3:0];
      obi_addr = v.addr; obi_wdata = v.wdata; obi_aid = v.aid[0:0];
      for (int c = 0; c < 20 && t_gnt < 0; c++) begin
         #1;
         if (obi_gnt) t_gnt = cyc;
         else @(negedge clk);
      end
      @(negedge clk);
      obi_req = 1'b0; obi_addr = 32'h2000_FFF0; obi_we = ~v.we[0];
      obi_wdata = ~v.wdata; obi_be = 4'h0; obi_aid = ~v.aid[0:0];
      chk(v.nm, "gnt", 32'(t_gnt >= 0), 32'd1);
      for (int c = 0; c < 30 && rv_cyc.size() == rv0; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      ns = st_cyc.size() - st0;
      nr = rv_cyc.size() - rv0;
      chk(v.nm, "starts", 32'(ns), 32'(v.starts));
      if (ns > 0 && v.starts > 0) begin
         last = st0 + ns - 1;
         chk(v.nm, "start_lat", 32'(st_cyc[st0] - t_gnt), 32'd1);
         chk(v.nm, "first_we", st_we[st0], v.fwe);
         chk(v.nm, "last_we", st_we[last], v.lwe);
         chk(v.nm, "spi_addr", st_addr[last], v.sa);
         if (v.lwe[0]) chk(v.nm, "spi_wdata", st_wdata[last], v.sw);
      end
      chk(v.nm, "rvalid_cnt", 32'(nr), 32'd1);
      if (nr > 0) begin
         chk(v.nm, "rv_lat", 32'(rv_cyc[rv0] - (v.starts > 0 ? rsp_cyc : t_gnt)), 32'd1);
         chk(v.nm, "rdata", rv_rdata[rv0], v.rd);
         chk(v.nm, "err", rv_err[rv0], v.err);
         chk(v.nm, "rid", rv_rid[rv0], v.rid);
      end
      chk(v.nm, "stable", 32'(stab_err - sb0), 32'd0);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk(tag, "ctl", 32'({obi_rvalid, obi_err, spi_start, spi_we, obi_rid}), 32'd0);
      chk(tag, "rdata", obi_rdata, 32'd0);
      chk(tag, "spi_addr", 32'(spi_addr), 32'd0);
      chk(tag, "spi_wdata", spi_wdata, 32'd0);
   endtask

   vec_t vecs[9];

   initial begin
      int st0, rv0, sb0, g1, g2, ngnt, t_gnt;

      vecs[0] = mk("full_wr", 1, 4'hF, 32'h2000_0104, 32'hDEAD_BEEF, 0, 0, 0, 1, 1, 1, 32'h000104, 32'hDEAD_BEEF, 0, 0, 0);
      vecs[1] = mk("rd_back", 0, 4'hF, 32'h2000_0104, 32'h0, 1, 0, 0, 1, 0, 0, 32'h000104, 0, 0, 32'hDEAD_BEEF, 1);
      vecs[2] = mk("rd_top", 0, 4'hF, 32'h2001_FFFC, 32'h0, 1, 1, 32'hCAFE_F00D, 1, 0, 0, 32'h01FFFC, 0, 0, 32'hCAFE_F00D, 1);
      vecs[3] = mk("miss_rd", 0, 4'hF, 32'h2002_0000, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      vecs[4] = mk("miss_wr", 1, 4'hF, 32'h1FFF_FFFC, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      vecs[5] = mk("unalign", 0, 4'hF, 32'h2000_0107, 32'h0, 0, 0, 0, 1, 0, 0, 32'h000104, 0, 0, 32'hDEAD_BEEF, 0);
`ifdef SPI_OBI_BRIDGE_RMW_EN
      vecs[6] = mk("part_wr", 1, 4'b0010, 32'h2000_0200, 32'h0000_AB00, 1, 1, 32'h1122_3344, 2, 0, 1, 32'h000200, 32'h1122_AB44, 0, 0, 1);
      vecs[7] = mk("part_rb", 0, 4'hF, 32'h2000_0200, 32'h0, 0, 0, 0, 1, 0, 0, 32'h000200, 0, 0, 32'h1122_AB44, 0);
      vecs[8] = mk("part_wr2", 1, 4'b1001, 32'h2000_0300, 32'hAABB_CCDD, 0, 1, 32'h0102_0304, 2, 0, 1, 32'h000300, 32'hAA02_03DD, 0, 0, 0);
`else
      vecs[6] = mk("part_wr", 1, 4'b0010, 32'h2000_0200, 32'h0000_AB00, 1, 1, 32'h1122_3344, 0, 0, 0, 32'h000200, 0, 1, 0, 1);
      vecs[7] = mk("part_rb", 0, 4'hF, 32'h2000_0200, 32'h0, 0, 0, 0, 1, 0, 0, 32'h000200, 0, 0, 32'h1122_3344, 0);
      vecs[8] = mk("part_wr2", 1, 4'b1001, 32'h2000_0300, 32'hAABB_CCDD, 0, 1, 32'h0102_0304, 0, 0, 0, 32'h000300, 0, 1, 0, 0);
`endif

      rst_n = 1'b0; obi_req = 1'b1; obi_we = 1'b0; obi_be = 4'hF;
      obi_addr = 32'h2000_0000; obi_wdata = 32'h0; obi_aid = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset", "gnt", 32'(obi_gnt), 32'd0);
      chk_idle_outputs("reset");
      @(negedge clk);
      obi_req = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      chk_idle_outputs("post_reset");

      for (int i = 0; i < 9; i++) run_txn(vecs[i]);

      // A response pulse while idle must not produce anything.
      @(negedge clk);
      st0 = st_cyc.size(); rv0 = rv_cyc.size();
      stray_rsp = 1'b1;
      repeat (2) @(negedge clk);
      stray_rsp = 1'b0;
      repeat (3) @(negedge clk);
      chk("stray", "rvalid_cnt", 32'(rv_cyc.size() - rv0), 32'd0);
      chk("stray", "starts", 32'(st_cyc.size() - st0), 32'd0);

      // Back-to-back reads with req held high.
      sram[24'h000010] = 32'h1111_0001;
      sram[24'h000014] = 32'h2222_0002;
      @(negedge clk);
      st0 = st_cyc.size(); rv0 = rv_cyc.size(); sb0 = stab_err;
      g1 = -1; g2 = -1; ngnt = 0;
      obi_req = 1'b1; obi_we = 1'b0; obi_be = 4'hF; obi_addr = 32'h2000_0010; obi_aid = 1'b0;
      for (int c = 0; c < 60 && !(g2 >= 0 && rv_cyc.size() - rv0 >= 2); c++) begin
         #1;
         if (obi_gnt) begin
            ngnt++;
            if (g1 < 0) g1 = cyc;
            else if (g2 < 0) g2 = cyc;
         end
         @(negedge clk);
         if (g1 >= 0 && g2 < 0) begin
            obi_addr = 32'h2000_0014; obi_aid = 1'b1;
         end
         if (g2 >= 0) obi_req = 1'b0;
      end
      obi_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("b2b", "grants", 32'(ngnt), 32'd2);
      chk("b2b", "starts", 32'(st_cyc.size() - st0), 32'd2);
      chk("b2b", "rvalid_cnt", 32'(rv_cyc.size() - rv0), 32'd2);
      if (rv_cyc.size() - rv0 >= 2 && st_cyc.size() - st0 >= 2) begin
         chk("b2b", "regrant_lat", 32'(g2 - rv_cyc[rv0]), 32'd1);
         chk("b2b", "addr0", st_addr[st0], 32'h000010);
         chk("b2b", "addr1", st_addr[st0+1], 32'h000014);
         chk("b2b", "rdata0", rv_rdata[rv0], 32'h1111_0001);
         chk("b2b", "rid0", rv_rid[rv0], 32'd0);
         chk("b2b", "rdata1", rv_rdata[rv0+1], 32'h2222_0002);
         chk("b2b", "rid1", rv_rid[rv0+1], 32'd1);
      end
      chk("b2b", "stable", 32'(stab_err - sb0), 32'd0);

      // Reset while waiting for the SPI response drops the transaction.
      @(negedge clk);
      st0 = st_cyc.size(); rv0 = rv_cyc.size();
      t_gnt = -1;
      obi_req = 1'b1; obi_we = 1'b0; obi_be = 4'hF; obi_addr = 32'h2000_0020; obi_aid = 1'b1;
      for (int c = 0; c < 20 && t_gnt < 0; c++) begin
         #1;
         if (obi_gnt) t_gnt = cyc;
         else @(negedge clk);
      end
      @(negedge clk);
      obi_req = 1'b0;
      chk("rst_wait", "gnt", 32'(t_gnt >= 0), 32'd1);
      for (int c = 0; c < 20 && st_cyc.size() == st0; c++) @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_idle_outputs("rst_wait");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("rst_wait", "rvalid_cnt", 32'(rv_cyc.size() - rv0), 32'd0);
      chk("rst_wait", "starts", 32'(st_cyc.size() - st0), 32'd1);

      run_txn(vecs[2]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
